// File: rtl/alu_muldiv_if.sv
// Operand/result handshake bundle for alu_muldiv.
interface alu_muldiv_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;

   // Requester side: presents operations, consumes results.
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, zero
   );

   // ALU side.
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_muldiv.sv
// Integer ALU with single-cycle logic/arith ops and radix-2 iterative
// multiply (shift-add) and unsigned divide (restoring).
module alu_muldiv #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input logic         clk,
   input logic         rst_n,
   alu_muldiv_if.slave bus
);

   localparam int unsigned DW = 2 * WIDTH;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // sel[1]: divide (else multiply); sel[0]: return high half (MULHU / REMU)
   logic [1:0]       sel_q, sel_d;
   // multiplicand for MUL/MULHU, divisor for DIVU/REMU
   logic [WIDTH-1:0] opnd_q, opnd_d;
   // {hi, lo}: product accumulator, or {remainder, dividend/quotient}
   logic [DW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] alu_res;
   logic             is_iter;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH:0]   mul_sum;
   logic [DW-1:0]    mul_next;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem;
   logic [DW-1:0]    div_next;
   logic [DW-1:0]    step_acc;
   logic [WIDTH-1:0] step_res;

   // Single-cycle operation result straight from the presented operands.
   always_comb begin
      alu_res = '0;
      case (bus.op)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
         OP_SLTU: alu_res = WIDTH'(bus.a < bus.b);
         default: alu_res = '0;
      endcase
      is_iter = (bus.op[3:2] == 2'b10);
   end

   // One radix-2 step of the multiply and of the divide.
   always_comb begin
      acc_hi    = acc_q[DW-1:WIDTH];
      acc_lo    = acc_q[WIDTH-1:0];
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      // when div_ge the difference is below the divisor, so WIDTH bits suffice
      div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
      div_next  = {div_rem, acc_lo[WIDTH-2:0], div_ge};
      step_acc  = sel_q[1] ? div_next : mul_next;
      step_res  = sel_q[0] ? step_acc[DW-1:WIDTH] : step_acc[WIDTH-1:0];
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               cnt_d  = '0;
               sel_d  = bus.op[1:0];
               opnd_d = bus.op[1] ? bus.b : bus.a;
               acc_d  = bus.op[1] ? {WIDTH'(0), bus.a} : {WIDTH'(0), bus.b};
               if (is_iter) begin
                  state_d = S_BUSY;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = S_DONE;
               end
            end
         end
         S_BUSY: begin
            acc_d = step_acc;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = step_res;
               zero_d   = (step_res == '0);
               cnt_d    = '0;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH = 32.
module tb_alu_muldiv;

   localparam int unsigned W  = 32;
   localparam int          NV = 27;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_MULHU = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;
   localparam logic [3:0] OP_REMU  = 4'b1011;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs [NV];

   alu_muldiv_if #(.WIDTH(W)) bus ();

   alu_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one op, scramble inputs after acceptance, wait for the result, then retire it.
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output int lat,
                         output logic busy_ok, output logic ready_after);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a  = x;
      bus.b  = y;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op = OP_ADD;
      bus.a  = 32'hDEAD_BEEF;
      bus.b  = 32'h0BAD_F00D;
      lat = 1;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      r = bus.result;
      z = bus.zero;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      ready_after = bus.in_ready && !bus.out_valid;
   endtask

   initial begin
      logic [31:0] r;
      logic        z;
      int          lat;
      logic        busy_ok, ready_after, stable_ok, quiet_ok;

      vecs[0]  = '{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
      vecs[1]  = '{OP_ADD,   32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1};
      vecs[2]  = '{OP_SUB,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};
      vecs[3]  = '{OP_SUB,   32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1, 1};
      vecs[4]  = '{OP_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1};
      vecs[5]  = '{OP_OR,    32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F, 1'b0, 1};
      vecs[6]  = '{OP_SLT,   32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
      vecs[7]  = '{OP_SLTU,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
      vecs[8]  = '{OP_SLT,   32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1, 1};
      vecs[9]  = '{OP_SLTU,  32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1};
      vecs[10] = '{4'b1111,  32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1};
      vecs[11] = '{4'b1100,  32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1};
      vecs[12] = '{OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33};
      vecs[13] = '{OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 33};
      vecs[14] = '{OP_MUL,   32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 33};
      vecs[15] = '{OP_MULHU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 1'b0, 33};
      vecs[16] = '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
      vecs[17] = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
      vecs[18] = '{OP_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 33};
      vecs[19] = '{OP_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 33};
      vecs[20] = '{OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 33};
      vecs[21] = '{OP_REMU,  32'd5,         32'd0,         32'd5,         1'b0, 33};
      vecs[22] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 33};
      vecs[23] = '{OP_REMU,  32'd7,         32'd7,         32'd0,         1'b1, 33};
      vecs[24] = '{OP_DIVU,  32'd3,         32'd10,        32'd0,         1'b1, 33};
      vecs[25] = '{OP_REMU,  32'hFFFF_FFFF, 32'd10,        32'd5,         1'b0, 33};
      vecs[26] = '{OP_DIVU,  32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 1'b0, 33};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = 4'h0;
      bus.a         = '0;
      bus.b         = '0;

      #22;
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset in_ready",  64'(bus.in_ready),  64'd1);
      check("reset result",    64'(bus.result),    64'd0);
      check("reset zero",      64'(bus.zero),      64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, busy_ok, ready_after);
         check($sformatf("v%0d result", i),  64'(r),   64'(vecs[i].res));
         check($sformatf("v%0d zero", i),    64'(z),   64'(vecs[i].z));
         check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
         if (vecs[i].lat > 1)
            check($sformatf("v%0d in_ready low while busy", i), 64'(busy_ok), 64'd1);
         check($sformatf("v%0d in_ready after retire", i), 64'(ready_after), 64'd1);
      end

      // Backpressure on a DIVU result, with an in_valid pulse that must be ignored
      bus.in_valid = 1'b1;
      bus.op = OP_DIVU;
      bus.a  = 32'd100;
      bus.b  = 32'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp latency", 64'(lat), 64'd33);
      stable_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            bus.in_valid = 1'b1;
            bus.op = OP_ADD;
            bus.a  = 32'd1;
            bus.b  = 32'd1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (!bus.out_valid || bus.result !== 32'd14 || bus.zero !== 1'b0 || bus.in_ready)
            stable_ok = 1'b0;
      end
      bus.in_valid = 1'b0;
      check("bp held stable", 64'(stable_ok), 64'd1);
      check("bp result", 64'(bus.result), 64'd14);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp in_ready after release",  64'(bus.in_ready),  64'd1);
      check("bp out_valid after release", 64'(bus.out_valid), 64'd0);
      quiet_ok = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) quiet_ok = 1'b0;
      end
      check("bp ignored pulse left no op", 64'(quiet_ok), 64'd1);

      // Reset in the middle of a MUL
      bus.in_valid = 1'b1;
      bus.op = OP_MUL;
      bus.a  = 32'd1234;
      bus.b  = 32'd5678;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (16) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-busy reset out_valid", 64'(bus.out_valid), 64'd0);
      check("mid-busy reset in_ready",  64'(bus.in_ready),  64'd1);
      check("mid-busy reset result",    64'(bus.result),    64'd0);
      check("mid-busy reset zero",      64'(bus.zero),      64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      quiet_ok = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid || bus.result !== 32'd0 || !bus.in_ready) quiet_ok = 1'b0;
      end
      check("no stale result after reset", 64'(quiet_ok), 64'd1);
      run_op(OP_ADD, 32'd2, 32'd3, r, z, lat, busy_ok, ready_after);
      check("post-reset add result",  64'(r),   64'd5);
      check("post-reset add zero",    64'(z),   64'd0);
      check("post-reset add latency", 64'(lat), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
